cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares one common data bus (GPR or FPR CDB) among N result producers (lw_sw load port, ALU, FPU, ...), each of which presents a valid/ready request.
- Grants at most one requester per cycle, round-robin, and broadcasts that requester's tag and result on the CDB in the following cycle.
- The one-cycle split matches producers that expose the tag combinationally at grant and register the result on the grant edge, as the load port does.
- One instance each sits in front of gpr_cdb and fpr_cdb.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ROB_WIDTH, from common package, tag width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous pipeline flush from the ROB (misprediction).
- req_valid  input  N_REQ  per-requester request; tag stable while asserted.
- req_tag  input  N_REQ x ROB_WIDTH  per-requester ROB tag, sampled in the grant cycle.
- req_data  input  N_REQ x DATA_WIDTH  per-requester result, sampled the cycle after grant.
- req_ready  output  N_REQ  one-hot-or-zero grant; the handshake completes when valid && ready.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  ROB_WIDTH  broadcast tag.
- cdb_data  output  DATA_WIDTH  broadcast data.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - grant_valid_q=0, grant_idx_q=0, grant_tag_q=0.
  - rr_last_q=N_REQ-1, so requester 0 has top priority after reset.
  - Outputs cdb_valid=0, cdb_tag=0, cdb_data=0, req_ready=0 for the whole duration of reset.
- Grant (combinational, cycle T):
  - Scan requesters in order rr_last_q+1, rr_last_q+2, ... modulo N_REQ.
  - The first index with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - If no requester is valid, or flush=1, all ready bits are 0.
  - ready never depends on req_data.
- Registers on the T edge when a grant is issued:
  - grant_valid_q<=1.
  - grant_idx_q<=winner.
  - grant_tag_q<=req_tag[winner].
  - rr_last_q<=winner.
- When no grant is issued in T: grant_valid_q<=0 and rr_last_q holds.
- Broadcast (cycle T+1):
  - cdb_valid = grant_valid_q && !flush.
  - cdb_tag = grant_tag_q.
  - cdb_data = req_data[grant_idx_q], a combinational mux.
  - When cdb_valid=0, cdb_tag and cdb_data are driven 0, never X.
- Latency and throughput:
  - Grant to broadcast is exactly 1 cycle.
  - One broadcast per cycle at full load.
  - A requester may re-request in T+1; it is lowest priority in that cycle's scan.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- Requester contract:
  - Drop valid after the handshake unless a new result is pending.
  - Hold req_data[idx] valid through T+1.
  - The arbiter does not check this contract.
- Flush:
  - In T: no grant.
  - In T+1: an in-flight broadcast is suppressed, and grant_valid_q clears on that edge.
  - rr_last_q is unchanged by flush.
- Simultaneous flush and requests: flush wins; requesters see ready=0 and must drop on their own flush.
- Reset mid-broadcast: cdb_valid falls asynchronously with rst_n.
- N_REQ=1: ready=valid&&!flush; the round-robin pointer is constant.
- Assertions (simulation only):
  - popcount(req_ready)<=1.
  - req_ready[i] implies req_valid[i].

Decomposition:
- Shared package (common.vh): cdb_t (valid, tag, data), ROB_WIDTH, and a new constant N_CDB_REQ=4 for the default requester count.
- Sub-module rr_picker: combinational, takes N_REQ-bit request vector plus last index and produces a one-hot grant and an encoded index. It is reused by the future issue-select logic.
- The arbiter top holds the registers, flush gating and output mux.

Test Plan:
1. Reset release, no requests -> cdb_valid=0, cdb_tag=0, cdb_data=0, req_ready=0000 for 5 cycles.
2. Only req 2 valid, tag=5, data=0x1234 one cycle later -> req_ready=0100 in T; cdb_valid=1, tag=5, data=0x1234 in T+1; nothing in T+2 after valid drops.
3. All four valid continuously after reset -> grant order 0,1,2,3,0; cdb_valid=1 every cycle from the second cycle.
4. Reqs 1 and 3 valid with rr_last=1 -> 3 granted first, then 1; never 1 twice in a row.
5. Grant to req 0 in T, flush=1 in T+1 -> cdb_valid=0 in T+1 and no grants in T+1; rr_last=0 retained, so the next grant scans from 1.
6. rst_n pulled low in T+1 of a grant -> cdb_valid=0 immediately; after release, requester 0 has top priority.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared definitions for the common data bus arbiters (GPR and FPR CDB).
//   - ROB_WIDTH   : ROB tag width used on every CDB
//   - DATA_WIDTH  : default result width
//   - N_CDB_REQ   : default number of producers sharing one CDB
//   - cdb_t       : one CDB broadcast beat (valid, tag, data)
//   - idx_width() : width of an encoded requester index (at least 1 bit)
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;
  localparam int N_CDB_REQ  = 4;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker. Scans the request vector starting one
//   position after `last` (wrapping modulo N_REQ) and selects the first set bit.
//   Ports:
//     req   in  [N_REQ-1:0]  request vector
//     last  in  [IDX_W-1:0]  index granted most recently (lowest priority now)
//     grant out [N_REQ-1:0]  one-hot-or-zero grant
//     idx   out [IDX_W-1:0]  encoded index of the granted bit (0 when none)
//     any   out              at least one request present
// -----------------------------------------------------------------------------
module rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(last) + k) % N_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares one common data bus among N_REQ result producers. One requester is
//   granted per cycle in round-robin order; its tag is captured on the grant
//   edge and its result is muxed onto the CDB in the following cycle, which
//   suits producers that register their result on the grant edge.
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset
//     flush      in   synchronous pipeline flush (blocks grants, kills broadcast)
//     req_valid  in   [N_REQ]              per-requester request
//     req_tag    in   [N_REQ][ROB_WIDTH]   per-requester ROB tag (grant cycle)
//     req_data   in   [N_REQ][DATA_WIDTH]  per-requester result (cycle after grant)
//     req_ready  out  [N_REQ]              one-hot-or-zero grant
//     cdb_valid  out  broadcast valid
//     cdb_tag    out  broadcast tag  (0 when not valid)
//     cdb_data   out  broadcast data (0 when not valid)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_REQ      = cdb_arbiter_pkg::N_CDB_REQ,
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0]      req_tag,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]                     req_ready,
  output logic                                 cdb_valid,
  output logic [ROB_WIDTH-1:0]                 cdb_tag,
  output logic [DATA_WIDTH-1:0]                cdb_data
);

  import cdb_arbiter_pkg::*;

  localparam int IDX_W = idx_width(N_REQ);

  logic [N_REQ-1:0]     grant_oh_p0;
  logic [IDX_W-1:0]     win_idx_p0;
  logic                 any_req_p0;
  logic                 grant_fire_p0;

  logic                 grant_vld_p1;
  logic [IDX_W-1:0]     grant_idx_p1;
  logic [ROB_WIDTH-1:0] grant_tag_p1;
  logic [IDX_W-1:0]     rr_last;

  // ---- stage p0: round-robin grant ----
  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .last  (rr_last),
    .grant (grant_oh_p0),
    .idx   (win_idx_p0),
    .any   (any_req_p0)
  );

  assign grant_fire_p0 = any_req_p0 && !flush;
  // rst_n gates ready so no handshake can complete while reset is held.
  assign req_ready     = (grant_fire_p0 && rst_n) ? grant_oh_p0 : '0;

  // ---- stage p0 -> p1: grant registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld_p1 <= 1'b0;
      grant_idx_p1 <= '0;
      grant_tag_p1 <= '0;
      rr_last      <= IDX_W'(N_REQ - 1);
    end else begin
      grant_vld_p1 <= grant_fire_p0;
      if (grant_fire_p0) begin
        grant_idx_p1 <= win_idx_p0;
        grant_tag_p1 <= req_tag[win_idx_p0];
        rr_last      <= win_idx_p0;
      end
    end
  end

  // ---- stage p1: broadcast ----
  assign cdb_valid = grant_vld_p1 && !flush;
  assign cdb_tag   = cdb_valid ? grant_tag_p1 : '0;
  assign cdb_data  = cdb_valid ? req_data[grant_idx_p1] : '0;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_ready_implies_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TW = cdb_arbiter_pkg::ROB_WIDTH;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][TW-1:0] req_tag;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                cdb_valid;
  logic [TW-1:0]       cdb_tag;
  logic [DW-1:0]       cdb_data;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .N_REQ      (N),
    .ROB_WIDTH  (TW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: last granted index and the pending broadcast.
  int          m_last;
  bit          m_pend;
  int          m_idx;
  logic [TW-1:0] m_tag;

  typedef struct {
    logic [N-1:0]  valid;
    logic          flush;
    logic [N-1:0]  ready;
    logic          cvld;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_pend = 1'b0;
    m_idx  = 0;
    m_tag  = '0;
  endtask

  // Winner = first valid requester after the last winner, wrapping around.
  function automatic int m_winner();
    if (!rst_n || flush) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_model(input string name);
    int            w;
    logic [N-1:0]  exp_ready;
    logic          exp_v;
    w = m_winner();
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    exp_v = rst_n && m_pend && !flush;
    chk({name, ".ready"}, 32'(req_ready), 32'(exp_ready));
    chk({name, ".cdb_valid"}, 32'(cdb_valid), 32'(exp_v));
    chk({name, ".cdb_tag"}, 32'(cdb_tag), exp_v ? 32'(m_tag) : 32'd0);
    chk({name, ".cdb_data"}, cdb_data, exp_v ? req_data[m_idx] : 32'd0);
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      w = m_winner();
      if (w >= 0) begin
        m_pend = 1'b1;
        m_idx  = w;
        m_tag  = req_tag[w];
        m_last = w;
      end else begin
        m_pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic default_payload();
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = TW'(8 + i);
      req_data[i] = 32'hA000 + 32'(i);
    end
  endtask

  initial begin
    //               valid    fl  ready    cv tag data
    tbl[0]  = '{4'b0000, 0, 4'b0000, 0, 0,  32'h0};
    tbl[1]  = '{4'b1111, 0, 4'b0001, 0, 0,  32'h0};
    tbl[2]  = '{4'b1111, 0, 4'b0010, 1, 8,  32'hA000};
    tbl[3]  = '{4'b1111, 0, 4'b0100, 1, 9,  32'hA001};
    tbl[4]  = '{4'b1111, 0, 4'b1000, 1, 10, 32'hA002};
    tbl[5]  = '{4'b1111, 0, 4'b0001, 1, 11, 32'hA003};
    tbl[6]  = '{4'b1010, 0, 4'b0010, 1, 8,  32'hA000};
    tbl[7]  = '{4'b1010, 0, 4'b1000, 1, 9,  32'hA001};
    tbl[8]  = '{4'b1010, 0, 4'b0010, 1, 11, 32'hA003};
    tbl[9]  = '{4'b0000, 0, 4'b0000, 1, 9,  32'hA001};
    tbl[10] = '{4'b0000, 0, 4'b0000, 0, 0,  32'h0};
    tbl[11] = '{4'b0001, 1, 4'b0000, 0, 0,  32'h0};
    tbl[12] = '{4'b0001, 0, 4'b0001, 0, 0,  32'h0};
    tbl[13] = '{4'b0001, 1, 4'b0000, 0, 0,  32'h0};
    tbl[14] = '{4'b0000, 0, 4'b0000, 0, 0,  32'h0};
    tbl[15] = '{4'b1001, 0, 4'b1000, 0, 0,  32'h0};
    tbl[16] = '{4'b0000, 0, 4'b0000, 1, 11, 32'hA003};

    default_payload();
    model_reset();

    // Held in reset with requests present: nothing may be granted or broadcast.
    req_valid = 4'b1111;
    @(negedge clk);
    chk("in_reset.ready", 32'(req_ready), 32'd0);
    chk("in_reset.cdb_valid", 32'(cdb_valid), 32'd0);
    advance();
    advance();
    req_valid = '0;
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle.ready", 32'(req_ready), 32'd0);
      chk("idle.cdb_valid", 32'(cdb_valid), 32'd0);
      chk("idle.cdb_tag", 32'(cdb_tag), 32'd0);
      chk("idle.cdb_data", cdb_data, 32'd0);
      check_model("idle");
      advance();
    end

    // Single requester 2: tag in T, data arrives in T+1.
    req_valid   = 4'b0100;
    req_tag[2]  = TW'(5);
    req_data[2] = 32'hDEAD;
    @(negedge clk);
    chk("single.T.ready", 32'(req_ready), 32'b0100);
    chk("single.T.cdb_valid", 32'(cdb_valid), 32'd0);
    check_model("single.T");
    advance();
    req_valid   = '0;
    req_data[2] = 32'h1234;
    @(negedge clk);
    chk("single.T1.cdb_valid", 32'(cdb_valid), 32'd1);
    chk("single.T1.cdb_tag", 32'(cdb_tag), 32'd5);
    chk("single.T1.cdb_data", cdb_data, 32'h1234);
    chk("single.T1.ready", 32'(req_ready), 32'd0);
    check_model("single.T1");
    advance();
    @(negedge clk);
    chk("single.T2.cdb_valid", 32'(cdb_valid), 32'd0);
    check_model("single.T2");
    advance();

    // Fresh reset, then the vector table (round robin, pairs, flush).
    default_payload();
    rst_n = 1'b0;
    model_reset();
    advance();
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_valid = tbl[i].valid;
      flush     = tbl[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("vec%0d.cdb_valid", i), 32'(cdb_valid), 32'(tbl[i].cvld));
      chk($sformatf("vec%0d.cdb_tag", i), 32'(cdb_tag), 32'(tbl[i].tag));
      chk($sformatf("vec%0d.cdb_data", i), cdb_data, tbl[i].data);
      check_model($sformatf("vec%0d", i));
      advance();
    end
    flush = 1'b0;

    // Reset asserted in the broadcast cycle of a grant to requester 0.
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rstmid.T.ready", 32'(req_ready), 32'b0001);
    check_model("rstmid.T");
    advance();
    req_valid = '0;
    #2;
    chk("rstmid.before.cdb_valid", 32'(cdb_valid), 32'd1);
    chk("rstmid.before.cdb_data", cdb_data, 32'hA000);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstmid.after.cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rstmid.after.cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rstmid.after.cdb_data", cdb_data, 32'd0);
    req_valid = 4'b1111;
    @(negedge clk);
    check_model("rstmid.held");
    advance();
    advance();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.release.ready", 32'(req_ready), 32'b0001);
    check_model("rstmid.release");
    advance();
    req_valid = '0;
    @(negedge clk);
    check_model("rstmid.drain");
    advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      for (int r = 0; r < N; r++) begin
        req_tag[r]  = TW'($urandom);
        req_data[r] = $urandom;
      end
      @(negedge clk);
      check_model("rand");
      advance();
    end
    flush     = 1'b0;
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
